light_mode_ctrl: RTL

- Mode sequencer for the three-color LED board.
- Debounces the two push keys and steps a mode state machine: OFF, RED, GREEN, BLUE, CYCLE.
- Applies a Switch-selected PWM brightness and drives LED[3:0].
- Sits between raw board pins (Key, Switch) and the LED pins; the top level instantiates it directly.

---
 rtl/light_pkg.sv | 22 ++
 rtl/key_debounce.sv | 30 +++
 rtl/light_mode_ctrl.sv | 63 ++++++
 3 files changed

// File: rtl/light_pkg.sv
// light_pkg: shared mode/color types, LED bit positions and duty fractions for the LED sequencer
package light_pkg;
  typedef enum logic [2:0] {
    M_OFF   = 3'd0,
    M_RED   = 3'd1,
    M_GREEN = 3'd2,
    M_BLUE  = 3'd3,
    M_CYCLE = 3'd4
  } mode_t;
  typedef enum logic [1:0] {
    C_RED   = 2'd0,
    C_GREEN = 2'd1,
    C_BLUE  = 2'd2
  } color_t;
  localparam int LED_R   = 0;
  localparam int LED_G   = 1;
  localparam int LED_B   = 2;
  localparam int LED_CYC = 3;
  localparam logic [1:0] DUTY_25 = 2'd1;
  localparam logic [1:0] DUTY_50 = 2'd2;
  localparam logic [1:0] DUTY_75 = 2'd3;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchronizer, stability counter and rising-edge press pulse for one raw key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic level, level_q;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync    <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], key};
      level_q <= level;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync[1];
      end else cnt <= cnt + 1'b1;
    end
  assign press = level & ~level_q;
endmodule

// File: rtl/light_mode_ctrl.sv
// light_mode_ctrl: debounced two-key mode sequencer driving a PWM-dimmed three-color LED
module light_mode_ctrl
  import light_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CYCLE_PERIOD    = 25000000,
  parameter int PWM_BITS        = 8
) (
  input  logic       Sys_CLK,
  input  logic       Sys_RST,
  input  logic [1:0] Key,
  input  logic [1:0] Switch,
  output logic [3:0] LED
);
  localparam int TW = $clog2(CYCLE_PERIOD + 1);
  logic nxt, prv, pwm_on;
  mode_t mode, mode_nxt;
  color_t idx, color;
  logic [TW-1:0] timer;
  logic [1:0] sw_s1, sw_s2, duty;
  logic [PWM_BITS-1:0] cnt;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(Sys_CLK), .rst(Sys_RST), .key(Key[0]), .press(nxt)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk(Sys_CLK), .rst(Sys_RST), .key(Key[1]), .press(prv)
  );
  always_comb
    mode_nxt = (nxt && prv) ? M_OFF
             : nxt ? ((mode == M_CYCLE) ? M_OFF : mode_t'(mode + 3'd1))
             : prv ? ((mode == M_OFF) ? M_CYCLE : mode_t'(mode - 3'd1))
             : mode;
  // Duty threshold is a quarter count scaled to the PWM counter range; 11 bypasses it.
  always_comb begin
    duty   = (sw_s2 == 2'b00) ? DUTY_25 : (sw_s2 == 2'b01) ? DUTY_50 : DUTY_75;
    pwm_on = (&sw_s2) || (cnt < (PWM_BITS'(duty) << (PWM_BITS - 2)));
    color  = (mode == M_CYCLE) ? idx : color_t'(2'(mode - 3'd1));
  end
  always_ff @(posedge Sys_CLK or posedge Sys_RST)
    if (Sys_RST) begin
      mode  <= M_OFF;
      idx   <= C_RED;
      timer <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
      cnt   <= '0;
      LED   <= '0;
    end else begin
      mode  <= mode_nxt;
      sw_s1 <= Switch;
      sw_s2 <= sw_s1;
      cnt   <= cnt + 1'b1;
      if (mode_nxt == M_CYCLE && mode != M_CYCLE) begin
        timer <= '0;
        idx   <= C_RED;
      end else if (mode == M_CYCLE && mode_nxt == M_CYCLE) begin
        timer <= (timer == TW'(CYCLE_PERIOD - 1)) ? '0 : timer + 1'b1;
        if (timer == TW'(CYCLE_PERIOD - 1)) idx <= (idx == C_BLUE) ? C_RED : color_t'(idx + 2'd1);
      end
      LED[LED_B:LED_R] <= (mode == M_OFF) ? 3'b000 : (3'b001 << color) & {3{pwm_on}};
      LED[LED_CYC]     <= (mode == M_CYCLE);
    end
endmodule
